lut_arbiter: RTL and testbench

LUT_ARBITER -- requirements
Module: lut_arbiter

---
 rtl/lut_pkg.sv | 14 +
 rtl/lut_rr_arbiter.sv | 49 ++++
 rtl/lut_arbiter.sv | 176 +++++++++++++++++
 tb/tb_lut_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// Shared FSM state type and datapath widths for the LUT arbiter.
package lut_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_e;

  localparam int DATA_W = 16;
  localparam int R2_W   = 32;

endpackage

// File: rtl/lut_rr_arbiter.sv
// One-hot round-robin grant over NUM_REQ requesters, with the search pointer register.
module lut_rr_arbiter
  import lut_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  int               sum;

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    sum         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (enable && !grant_valid && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lut_arbiter.sv
// Shares one pipelined LUT among NUM_REQ PEs: table load FSM, round-robin grant, tag pipeline.
// Optional perf_grants/perf_stalls counters are built when LUT_ARB_PERF_CNT_EN is defined.
module lut_arbiter
  import lut_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SEG_BITS    = 8,
  parameter int LUT_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*R2_W-1:0]    req_r2,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic signed [DATA_W-1:0]   rsp_data,
  input  logic                       cfg_load_req,
  input  logic                       cfg_valid,
  input  logic                       cfg_last,
  input  logic [SEG_BITS-1:0]        cfg_addr,
  input  logic [DATA_W-1:0]          cfg_base,
  input  logic [DATA_W-1:0]          cfg_slope,
  output logic                       cfg_ready,
  output logic                       lut_conf_wr_en,
  output logic [SEG_BITS-1:0]        lut_conf_addr,
  output logic [DATA_W-1:0]          lut_conf_base,
  output logic [DATA_W-1:0]          lut_conf_slope,
  output logic                       lut_req_valid,
  output logic [R2_W-1:0]            lut_r2,
  input  logic signed [DATA_W-1:0]   lut_data_in,
  input  logic                       lut_ready,
  output logic                       table_loaded,
  output logic                       proto_err
`ifdef LUT_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                perf_grants,
  output logic [31:0]                perf_stalls
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LUT_LATENCY + 1);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_e                   state_q, state_d;
  tag_t [LUT_LATENCY-1:0]   tag_q, tag_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic signed [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                     table_loaded_q, table_loaded_d;
  logic                     proto_err_q, proto_err_d;
  logic [CNT_W-1:0]         inflight;
  logic                     arb_en;
  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  tag_t                     tail;

  // A reload request in RUN suppresses the grant in that same cycle.
  assign arb_en = (state_q == RUN) && !cfg_load_req;

  lut_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (arb_en),
    .req_valid   (req_valid),
    .grant       (req_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign cfg_ready      = (state_q == LOAD);
  assign lut_conf_wr_en = cfg_valid && cfg_ready;
  assign lut_conf_addr  = cfg_addr;
  assign lut_conf_base  = cfg_base;
  assign lut_conf_slope = cfg_slope;
  assign lut_req_valid  = grant_valid;
  assign tail           = tag_q[LUT_LATENCY-1];

  always_comb begin
    lut_r2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) lut_r2 = req_r2[i*R2_W +: R2_W];
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LUT_LATENCY; k++) begin
      inflight = inflight + CNT_W'(tag_q[k].valid);
    end
  end

  always_comb begin
    state_d        = state_q;
    table_loaded_d = table_loaded_q;
    case (state_q)
      IDLE:  if (cfg_load_req) state_d = LOAD;
      LOAD: begin
        if (cfg_valid && cfg_last) begin
          state_d        = RUN;
          table_loaded_d = 1'b1;
        end
      end
      RUN:   if (cfg_load_req) state_d = DRAIN;
      DRAIN: if (inflight == '0) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Tags shift unconditionally; the LUT must answer exactly when the tail tag is valid.
  always_comb begin
    tag_d[0].valid = grant_valid;
    tag_d[0].idx   = grant_idx;
    for (int k = 1; k < LUT_LATENCY; k++) tag_d[k] = tag_q[k-1];
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (lut_ready && tail.valid) begin
      rsp_valid_d[tail.idx] = 1'b1;
      rsp_data_d            = lut_data_in;
    end
    proto_err_d = proto_err_q | (lut_ready != tail.valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tag_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      table_loaded_q <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tag_q          <= tag_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      table_loaded_q <= table_loaded_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign table_loaded = table_loaded_q;
  assign proto_err    = proto_err_q;

`ifdef LUT_ARB_PERF_CNT_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Saturating counters; a stall is any cycle with a request but no grant.
  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_stalls_d = perf_stalls_q;
    if (grant_valid && (perf_grants_q != '1)) perf_grants_d = perf_grants_q + 32'd1;
    if ((|req_valid) && !grant_valid && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed self-checking bench for lut_arbiter: load, round-robin, latency, reload, error, reset.
module tb_lut_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int SEG_BITS    = 8;
  localparam int LUT_LATENCY = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [3:0]           req_valid;
  logic [127:0]         req_r2;
  logic [3:0]           req_ready;
  logic [3:0]           rsp_valid;
  logic [15:0]          rsp_data;
  logic                 cfg_load_req;
  logic                 cfg_valid;
  logic                 cfg_last;
  logic [SEG_BITS-1:0]  cfg_addr;
  logic [15:0]          cfg_base;
  logic [15:0]          cfg_slope;
  logic                 cfg_ready;
  logic                 lut_conf_wr_en;
  logic [SEG_BITS-1:0]  lut_conf_addr;
  logic [15:0]          lut_conf_base;
  logic [15:0]          lut_conf_slope;
  logic                 lut_req_valid;
  logic [31:0]          lut_r2;
  logic [15:0]          lut_data_in;
  logic                 lut_ready;
  logic                 table_loaded;
  logic                 proto_err;
`ifdef LUT_ARB_PERF_CNT_EN
  logic [31:0]          perf_grants;
  logic [31:0]          perf_stalls;
`endif

  int         errors = 0;
  int         checks = 0;
  int         wr_pulses;
  logic [3:0] hist [3];
  logic [3:0] last_exp;
  logic       force_ready = 1'b0;
  logic [1:0] lut_pipe = 2'b00;
  logic [15:0] lut_dpipe0 = 16'h0;
  logic [15:0] lut_dpipe1 = 16'h0;

  always #5 clk = ~clk;

  lut_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .SEG_BITS    (SEG_BITS),
    .LUT_LATENCY (LUT_LATENCY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_r2         (req_r2),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .cfg_load_req   (cfg_load_req),
    .cfg_valid      (cfg_valid),
    .cfg_last       (cfg_last),
    .cfg_addr       (cfg_addr),
    .cfg_base       (cfg_base),
    .cfg_slope      (cfg_slope),
    .cfg_ready      (cfg_ready),
    .lut_conf_wr_en (lut_conf_wr_en),
    .lut_conf_addr  (lut_conf_addr),
    .lut_conf_base  (lut_conf_base),
    .lut_conf_slope (lut_conf_slope),
    .lut_req_valid  (lut_req_valid),
    .lut_r2         (lut_r2),
    .lut_data_in    (lut_data_in),
    .lut_ready      (lut_ready),
    .table_loaded   (table_loaded),
    .proto_err      (proto_err)
`ifdef LUT_ARB_PERF_CNT_EN
    ,
    .perf_grants    (perf_grants),
    .perf_stalls    (perf_stalls)
`endif
  );

  // External LUT model: returns r2[15:0] two cycles after each request.
  always @(posedge clk) begin
    lut_pipe   <= {lut_pipe[0], lut_req_valid};
    lut_dpipe0 <= lut_r2[15:0];
    lut_dpipe1 <= lut_dpipe0;
  end

  assign lut_ready   = force_ready | lut_pipe[1];
  assign lut_data_in = lut_dpipe1;

  function automatic int ohIdx(input logic [3:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // PE i carries r2 = 0x100 + 0x23*i, so PE1 yields 0x0123.
  function automatic logic [15:0] expData(input int idx);
    return 16'h0100 + 16'(idx * 35);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's requests and check grant, LUT request and the response due now.
  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] exp_ready);
    req_valid = valid;
    last_exp  = exp_ready;
    #2;
    checkOutput("req_ready", {28'h0, req_ready}, {28'h0, exp_ready});
    checkOutput("lut_req_valid", {31'h0, lut_req_valid}, {31'h0, |exp_ready});
    checkOutput("lut_r2", lut_r2, (exp_ready != 4'b0) ? {16'h0, expData(ohIdx(exp_ready))} : 32'h0);
    checkOutput("rsp_valid", {28'h0, rsp_valid}, {28'h0, hist[2]});
    if (hist[2] != 4'b0) checkOutput("rsp_data", {16'h0, rsp_data}, {16'h0, expData(ohIdx(hist[2]))});
  endtask

  task automatic endCycle();
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = last_exp;
    @(negedge clk);
  endtask

  initial begin
    req_valid    = 4'b0;
    req_r2       = {32'h0000_0169, 32'h0000_0146, 32'h0000_0123, 32'h0000_0100};
    cfg_load_req = 1'b0;
    cfg_valid    = 1'b0;
    cfg_last     = 1'b0;
    cfg_addr     = '0;
    cfg_base     = '0;
    cfg_slope    = '0;
    last_exp     = 4'b0;
    for (int i = 0; i < 3; i++) hist[i] = 4'b0;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
      checkOutput("rst_table_loaded", {31'h0, table_loaded}, 32'h0);
      checkOutput("rst_proto_err", {31'h0, proto_err}, 32'h0);
      checkOutput("rst_cfg_ready", {31'h0, cfg_ready}, 32'h0);
      endCycle();
    end
    rst_n = 1'b1;

    // Requests while unloaded are never granted.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1111, 4'b0000);
      endCycle();
    end

    cfg_load_req = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("idle_cfg_ready", {31'h0, cfg_ready}, 32'h0);
`ifdef LUT_ARB_PERF_CNT_EN
    checkOutput("perf_stalls_unloaded", perf_stalls, 32'd10);
    checkOutput("perf_grants_unloaded", perf_grants, 32'd0);
`endif
    endCycle();

    wr_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cfg_load_req = (i == 0);
      cfg_valid    = 1'b1;
      cfg_last     = (i == 2);
      cfg_addr     = SEG_BITS'(i);
      cfg_base     = 16'h1000 + 16'(i);
      cfg_slope    = 16'h0200 + 16'(i * 3);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("load_cfg_ready", {31'h0, cfg_ready}, 32'h1);
      checkOutput("load_wr_en", {31'h0, lut_conf_wr_en}, 32'h1);
      checkOutput("load_addr", {24'h0, lut_conf_addr}, 32'(i));
      checkOutput("load_base", {16'h0, lut_conf_base}, 32'h1000 + 32'(i));
      checkOutput("load_slope", {16'h0, lut_conf_slope}, 32'h0200 + 32'(i * 3));
      if (lut_conf_wr_en) wr_pulses++;
      endCycle();
    end
    cfg_load_req = 1'b0;
    cfg_valid    = 1'b0;
    cfg_last     = 1'b0;
    checkOutput("wr_pulses", 32'(wr_pulses), 32'd3);

    // Grants begin immediately after the final entry and rotate 0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 4'(1 << (i % 4)));
      if (i == 0) begin
        checkOutput("run_table_loaded", {31'h0, table_loaded}, 32'h1);
        checkOutput("run_cfg_ready", {31'h0, cfg_ready}, 32'h0);
        checkOutput("run_wr_en", {31'h0, lut_conf_wr_en}, 32'h0);
      end
      endCycle();
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0100, 4'b0100);
      endCycle();
    end

    // ptr now points at PE3; a lone PE1 request is granted.
    applyStimulus(4'b0010, 4'b0010);
    endCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000, 4'b0000);
      if (i == 2) begin
        checkOutput("latency_rsp_valid", {28'h0, rsp_valid}, 32'h2);
        checkOutput("latency_rsp_data", {16'h0, rsp_data}, 32'h0123);
      end
      endCycle();
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1111, 4'(1 << ((i + 2) % 4)));
      endCycle();
    end

    applyStimulus(4'b1111, 4'b0001);
`ifdef LUT_ARB_PERF_CNT_EN
    checkOutput("perf_grants_run", perf_grants, 32'd23);
    checkOutput("perf_stalls_run", perf_stalls, 32'd10);
`endif
    endCycle();
    applyStimulus(4'b1111, 4'b0010);
    endCycle();

    // Reload with two lookups in flight: no grant now, through DRAIN, or in LOAD.
    cfg_load_req = 1'b1;
    applyStimulus(4'b1111, 4'b0000);
    endCycle();
    applyStimulus(4'b1111, 4'b0000);
    checkOutput("drain_cfg_ready_0", {31'h0, cfg_ready}, 32'h0);
    endCycle();
    applyStimulus(4'b1111, 4'b0000);
    checkOutput("drain_cfg_ready_1", {31'h0, cfg_ready}, 32'h0);
    endCycle();

    cfg_load_req = 1'b0;
    cfg_valid    = 1'b1;
    cfg_last     = 1'b1;
    cfg_addr     = 8'h07;
    cfg_base     = 16'hBEEF;
    cfg_slope    = 16'h0042;
    applyStimulus(4'b1111, 4'b0000);
    checkOutput("reload_cfg_ready", {31'h0, cfg_ready}, 32'h1);
    checkOutput("reload_wr_en", {31'h0, lut_conf_wr_en}, 32'h1);
    checkOutput("reload_table_loaded", {31'h0, table_loaded}, 32'h1);
    endCycle();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("rerun_cfg_ready", {31'h0, cfg_ready}, 32'h0);
    checkOutput("rerun_table_loaded", {31'h0, table_loaded}, 32'h1);
`ifdef LUT_ARB_PERF_CNT_EN
    checkOutput("perf_grants_reload", perf_grants, 32'd25);
    checkOutput("perf_stalls_reload", perf_stalls, 32'd14);
`endif
    endCycle();

    // lut_ready with no outstanding tag raises a sticky proto_err and no response.
    force_ready = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("err_before", {31'h0, proto_err}, 32'h0);
    endCycle();
    force_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("err_sticky", {31'h0, proto_err}, 32'h1);
      endCycle();
    end

    // Reset with a lookup in flight discards it without a response.
    applyStimulus(4'b1111, 4'b0100);
    endCycle();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = 4'b0;
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("midrst_table_loaded", {31'h0, table_loaded}, 32'h0);
    checkOutput("midrst_proto_err", {31'h0, proto_err}, 32'h0);
    endCycle();
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    endCycle();
    applyStimulus(4'b0000, 4'b0000);
    endCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
